// File: rtl/seg_display_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_display_driver_if : request handshake into the display driver    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface seg_display_driver_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_2s_comp;
    logic                  i_hex_mode;
    logic                  i_valid;
    logic                  o_ready;

    modport master (
        output i_data, i_2s_comp, i_hex_mode, i_valid,
        input  o_ready
    );

    modport slave (
        input  i_data, i_2s_comp, i_hex_mode, i_valid,
        output o_ready
    );
endinterface
`default_nettype wire

// File: rtl/seg_display_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg_display_driver : binary -> 7-seg codes, shifted out to SR chain   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg_display_driver #(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_DIGITS     = 5,
    parameter int CLK_DIV        = 4,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  wire                       clk,
    input  wire                       rst,
    seg_display_driver_if.slave       bus,
    output logic                      o_sr_data,
    output logic                      o_sr_clk,
    output logic                      o_sr_latch,
    output logic                      o_overflow,
    output logic                      o_busy
);
    localparam int BCD_DIGITS = (DATA_WIDTH * 301) / 1000 + 1;
    localparam int HEX_DIGITS = (DATA_WIDTH + 3) / 4;
    localparam int MAG_DIGITS = (BCD_DIGITS > HEX_DIGITS) ? BCD_DIGITS : HEX_DIGITS;
    localparam int DV         = (MAG_DIGITS > NUM_DIGITS) ? MAG_DIGITS : NUM_DIGITS;
    localparam int BW         = 4 * DV;
    localparam int BITS       = 8 * NUM_DIGITS;
    localparam int CNT_W      = $clog2(DATA_WIDTH + 1);
    localparam int DIV_W      = $clog2(CLK_DIV + 1);
    localparam int BIT_W      = $clog2(BITS);
    localparam logic INV      = (SEG_ACTIVE_LOW != 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CONVERT = 3'd1,
        S_ENCODE  = 3'd2,
        S_SHIFT   = 3'd3,
        S_LATCH   = 3'd4
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] bin_q;
    logic [BW-1:0]         bcd_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DIV_W-1:0]      div_q;
    logic [BIT_W-1:0]      bit_q;
    logic [BITS-1:0]       shreg_q;
    logic                  neg_q;
    logic                  hex_q;
    logic                  sr_data_q;
    logic                  sr_clk_q;
    logic                  latch_q;
    logic                  ovf_q;

    logic [DATA_WIDTH-1:0] mag_d;
    logic [BW-1:0]         bcd_adj_d;
    logic [BW-1:0]         bcd_step_d;
    logic [BITS-1:0]       bytes_d;
    logic                  ovf_d;
    int                    sig_d;
    int                    needed_d;

    function automatic logic [7:0] seg_code(input logic [3:0] v);
        case (v)
            4'h0:    seg_code = 8'h3F;
            4'h1:    seg_code = 8'h06;
            4'h2:    seg_code = 8'h5B;
            4'h3:    seg_code = 8'h4F;
            4'h4:    seg_code = 8'h66;
            4'h5:    seg_code = 8'h6D;
            4'h6:    seg_code = 8'h7D;
            4'h7:    seg_code = 8'h07;
            4'h8:    seg_code = 8'h7F;
            4'h9:    seg_code = 8'h6F;
            4'hA:    seg_code = 8'h77;
            4'hB:    seg_code = 8'h7C;
            4'hC:    seg_code = 8'h39;
            4'hD:    seg_code = 8'h5E;
            4'hE:    seg_code = 8'h79;
            default: seg_code = 8'h71;
        endcase
    endfunction

    assign mag_d = (bus.i_2s_comp && bus.i_data[DATA_WIDTH-1])
                 ? (DATA_WIDTH'(0) - bus.i_data) : bus.i_data;

    // One double-dabble step: correct every BCD digit, then shift the next binary bit in.
    always_comb begin
        bcd_adj_d = bcd_q;
        for (int d = 0; d < DV; d++) begin
            if (bcd_q[4*d +: 4] >= 4'd5)
                bcd_adj_d[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
        end
        bcd_step_d = (bcd_adj_d << 1) | BW'(bin_q[DATA_WIDTH-1]);
    end

    always_comb begin
        sig_d = 1;
        for (int p = 0; p < DV; p++) begin
            if (bcd_q[4*p +: 4] != 4'd0)
                sig_d = p + 1;
        end
        needed_d = sig_d + (neg_q ? 1 : 0);
        ovf_d    = (needed_d > NUM_DIGITS);
        bytes_d  = '0;
        for (int p = 0; p < NUM_DIGITS; p++) begin
            if (ovf_d) begin
                if (p == 0)
                    bytes_d[8*p +: 8] = 8'h79;
            end else if (p < sig_d) begin
                bytes_d[8*p +: 8] = seg_code(bcd_q[4*p +: 4]);
            end else if (neg_q && (p == sig_d)) begin
                bytes_d[8*p +: 8] = 8'h40;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            neg_q     <= 1'b0;
            hex_q     <= 1'b0;
            sr_data_q <= 1'b0;
            sr_clk_q  <= 1'b0;
            latch_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        bin_q   <= mag_d;
                        neg_q   <= bus.i_2s_comp && bus.i_data[DATA_WIDTH-1];
                        hex_q   <= bus.i_hex_mode;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    if (hex_q) begin
                        bcd_q   <= BW'(bin_q);
                        state_q <= S_ENCODE;
                    end else begin
                        bcd_q <= bcd_step_d;
                        bin_q <= bin_q << 1;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_WIDTH - 1))
                            state_q <= S_ENCODE;
                    end
                end
                S_ENCODE: begin
                    // shreg_q holds the bits still to be sent; the first one goes straight out.
                    shreg_q   <= bytes_d << 1;
                    sr_data_q <= bytes_d[BITS-1] ^ INV;
                    sr_clk_q  <= 1'b0;
                    div_q     <= '0;
                    bit_q     <= '0;
                    ovf_q     <= ovf_d;
                    state_q   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (div_q == DIV_W'(CLK_DIV - 1)) begin
                        div_q <= '0;
                        if (!sr_clk_q) begin
                            sr_clk_q <= 1'b1;
                        end else if (bit_q == BIT_W'(BITS - 1)) begin
                            sr_clk_q  <= 1'b0;
                            sr_data_q <= 1'b0;
                            latch_q   <= 1'b1;
                            state_q   <= S_LATCH;
                        end else begin
                            sr_clk_q  <= 1'b0;
                            sr_data_q <= shreg_q[BITS-1] ^ INV;
                            shreg_q   <= shreg_q << 1;
                            bit_q     <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                S_LATCH: begin
                    if (div_q == DIV_W'(CLK_DIV - 1)) begin
                        div_q   <= '0;
                        latch_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_ready = (state_q == S_IDLE) && !rst;
    assign o_busy      = (state_q != S_IDLE) && !rst;
    assign o_sr_data   = sr_data_q;
    assign o_sr_clk    = sr_clk_q;
    assign o_sr_latch  = latch_q;
    assign o_overflow  = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_seg_display_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seg_display_driver : randomized bench with a behavioural model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_seg_display_driver;
    localparam int DW    = 16;
    localparam int ND    = 5;
    localparam int CD    = 2;
    localparam int AL    = 0;
    localparam int NBITS = 8 * ND;
    localparam logic [7:0] SEG [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic o_sr_data, o_sr_clk, o_sr_latch, o_overflow, o_busy;
    int   n_vec = 0;
    int   n_err = 0;
    logic last_ovf = 1'b0;

    seg_display_driver_if #(.DATA_WIDTH(DW)) bus ();

    seg_display_driver #(
        .DATA_WIDTH(DW), .NUM_DIGITS(ND), .CLK_DIV(CD), .SEG_ACTIVE_LOW(AL)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .o_sr_data(o_sr_data), .o_sr_clk(o_sr_clk), .o_sr_latch(o_sr_latch),
        .o_overflow(o_overflow), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Serial-link observer: what an external shift register chain would capture.
    int   rise_cnt = 0, latch_cyc = 0, latch_pulses = 0, hi_viol = 0, data_viol = 0, hi_len = 0;
    logic prev_clk = 1'b0, prev_data = 1'b0, prev_latch = 1'b0;
    bit   bits_q[$];

    always @(negedge clk) begin
        if (o_sr_clk && !prev_clk) begin
            rise_cnt++;
            bits_q.push_back(o_sr_data ^ bit'(AL));
            hi_len = 1;
        end else if (o_sr_clk) begin
            hi_len++;
        end
        if (o_sr_clk && (o_sr_data !== prev_data)) data_viol++;
        if (!o_sr_clk && prev_clk && hi_len != CD) hi_viol++;
        if (o_sr_latch) latch_cyc++;
        if (o_sr_latch && !prev_latch) latch_pulses++;
        prev_clk   = o_sr_clk;
        prev_data  = o_sr_data;
        prev_latch = o_sr_latch;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [DW-1:0] d, input bit sgn, input bit hex,
                                  output logic [NBITS-1:0] bytes, output bit ovf);
        int mag, radix;
        bit neg;
        int dig[$];
        neg   = sgn && d[DW-1];
        mag   = neg ? ((1 << DW) - int'(d)) : int'(d);
        radix = hex ? 16 : 10;
        do begin
            dig.push_back(mag % radix);
            mag = mag / radix;
        end while (mag > 0);
        ovf   = (dig.size() + int'(neg)) > ND;
        bytes = '0;
        if (ovf) begin
            bytes[7:0] = 8'h79;
        end else begin
            for (int p = 0; p < dig.size(); p++) bytes[8*p +: 8] = SEG[dig[p]];
            if (neg) bytes[8*dig.size() +: 8] = 8'h40;
        end
    endfunction

    task automatic apply(input logic [DW-1:0] d, input bit sgn, input bit hex, input bit glitch);
        logic [NBITS-1:0] exp_bytes, got_bytes;
        bit exp_ovf;
        int n, lat, w, b0, r0, lc0, lp0, hv0, dv0;
        model(d, sgn, hex, exp_bytes, exp_ovf);
        lat = (hex ? 1 : DW) + 1 + 16 * CD * ND + CD + 1;
        w = 0;
        while (!bus.o_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("idle_ready", bus.o_ready, 1);
        chk("ovf_hold", o_overflow, last_ovf);
        b0 = bits_q.size(); r0 = rise_cnt; lc0 = latch_cyc; lp0 = latch_pulses;
        hv0 = hi_viol; dv0 = data_viol;
        bus.i_data = d; bus.i_2s_comp = sgn; bus.i_hex_mode = hex; bus.i_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.i_valid = 1'b0;
                chk("busy", o_busy, 1);
                chk("ovf_clear", o_overflow, 0);
            end
            if (glitch && n == 40) begin
                bus.i_valid = 1'b1;
                bus.i_data  = DW'($urandom);
            end
            if (glitch && n == 41) bus.i_valid = 1'b0;
        end while (!bus.o_ready && n < 2000);
        got_bytes = '0;
        for (int i = 0; i < NBITS; i++)
            got_bytes = {got_bytes[NBITS-2:0], (b0 + i < bits_q.size()) ? bits_q[b0+i] : 1'b0};
        chk("latency", n, lat);
        chk("bytes", got_bytes, exp_bytes);
        chk("overflow", o_overflow, exp_ovf);
        chk("sr_rises", rise_cnt - r0, NBITS);
        chk("latch_cycles", latch_cyc - lc0, CD);
        chk("latch_pulses", latch_pulses - lp0, 1);
        chk("clk_high_len", hi_viol - hv0, 0);
        chk("data_stable", data_viol - dv0, 0);
        last_ovf = exp_ovf;
    endtask

    initial begin
        int lp0;
        bus.i_data = '0; bus.i_2s_comp = 1'b0; bus.i_hex_mode = 1'b0; bus.i_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", {o_sr_data, o_sr_clk, o_sr_latch, o_overflow, o_busy, bus.o_ready}, 6'b0);
        rst = 1'b0;
        #1;
        chk("rst_release_ready", bus.o_ready, 1);
        @(negedge clk);

        apply(16'd1234, 1'b0, 1'b0, 1'b0);
        apply(16'hFFF9, 1'b1, 1'b0, 1'b0);
        apply(16'h8000, 1'b1, 1'b0, 1'b0);

        // Abort a transfer halfway through the shift.
        lp0 = latch_pulses;
        bus.i_data = 16'd1234; bus.i_2s_comp = 1'b0; bus.i_hex_mode = 1'b0; bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (DW + 1 + 30) @(negedge clk);
        chk("mid_shift_busy", o_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_outs", {o_sr_data, o_sr_clk, o_sr_latch, o_overflow, o_busy, bus.o_ready}, 6'b0);
        rst = 1'b0;
        #1;
        chk("rst_ready", bus.o_ready, 1);
        repeat (3 * CD + 5) @(negedge clk);
        chk("no_latch_after_abort", latch_pulses - lp0, 0);
        last_ovf = 1'b0;

        apply(16'hBEEF, 1'b0, 1'b1, 1'b0);
        apply(16'h8000, 1'b1, 1'b1, 1'b0);
        apply(16'd0,    1'b0, 1'b0, 1'b0);
        apply(16'hFFFF, 1'b0, 1'b0, 1'b0);
        apply(16'd42,   1'b1, 1'b0, 1'b1);

        for (int k = 0; k < 30; k++) begin
            logic [DW-1:0] d;
            d = ($urandom_range(3) == 0) ? DW'($urandom_range(0, 20)) : DW'($urandom);
            apply(d, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
